// File: rtl/mem_bus_ctrl_pkg.sv
// Shared types and constants for the mem-stage RIB bus controller:
// FSM state encodings, access-size codes, bus/hold levels and the latched request.
package mem_bus_ctrl_pkg;

    typedef enum logic [1:0] {
        MBC_IDLE = 2'b00,
        MBC_REQ  = 2'b01,
        MBC_RESP = 2'b10,
        MBC_DONE = 2'b11
    } mbc_state_e;

    localparam logic [1:0] MEM_SIZE_B = 2'b00;
    localparam logic [1:0] MEM_SIZE_H = 2'b01;
    localparam logic [1:0] MEM_SIZE_W = 2'b10;
    localparam logic [1:0] MEM_SIZE_X = 2'b11;

    localparam logic RIB_REQ     = 1'b1;
    localparam logic RIB_NREQ    = 1'b0;
    localparam logic HoldEnable  = 1'b1;
    localparam logic HoldDisable = 1'b0;

    localparam logic [31:0] ZeroWord = 32'h0000_0000;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
    } mbc_req_t;

endpackage

// File: rtl/mem_sel_gen.sv
// Byte-lane strobe encoder: access size + address low bits -> sel[3:0].
// Latency: purely combinational.
// Backpressure: none; reserved size code yields an empty strobe.
module mem_sel_gen
    import mem_bus_ctrl_pkg::*;
(
    input  logic [1:0] size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] sel_o
);

    always_comb begin
        sel_o = 4'b0000;
        case (size_i)
            MEM_SIZE_B: sel_o = 4'b0001 << addr_lo_i;
            MEM_SIZE_H: sel_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            MEM_SIZE_W: sel_o = 4'b1111;
            default:    sel_o = 4'b0000;
        endcase
    end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Turns the mem stage's single-cycle request into a RIB req/gnt/rvalid transaction.
// Latency: best case 3 stall cycles (IDLE, REQ, RESP), DONE releases hold_o.
// Backpressure: hold_o stalls the pipeline; MEM_BUS_TIMEOUT_EN adds a bus timeout.
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] raddr_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic        int_assert_i,
    output logic        rib_req_o,
    output logic        rib_we_o,
    output logic [31:0] rib_addr_o,
    output logic [31:0] rib_wdata_o,
    output logic [3:0]  rib_sel_o,
    input  logic        rib_gnt_i,
    input  logic        rib_rvalid_i,
    input  logic [31:0] rib_rdata_i,
    output logic [31:0] rdata_o,
    output logic        hold_o,
    output logic        err_o
);

    mbc_state_e  state_q, state_d;
    mbc_req_t    req_q, req_d;
    logic        int_seen_q, int_seen_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_ok;
    logic        resp_drop;
    logic        timeout_hit;
    logic [31:0] in_addr;
    logic [3:0]  in_sel;

    assign req_ok    = req_i & ~int_assert_i;
    assign in_addr   = we_i ? waddr_i : raddr_i;
    // An interrupt seen at any point after the grant discards the response.
    assign resp_drop = int_seen_q | int_assert_i;

    mem_sel_gen u_sel_gen (
        .size_i    (size_i),
        .addr_lo_i (in_addr[1:0]),
        .sel_o     (in_sel)
    );

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] cnt_q, cnt_d;

    // Counter sits at zero outside REQ/RESP, so entry to REQ always starts from 0.
    always_comb begin
        cnt_d       = 8'd0;
        timeout_hit = 1'b0;
        case (state_q)
            MBC_REQ: begin
                cnt_d       = cnt_q + 8'd1;
                timeout_hit = (cnt_q == TO_LAST) && !rib_gnt_i && !int_assert_i;
            end
            MBC_RESP: begin
                cnt_d       = cnt_q + 8'd1;
                timeout_hit = (cnt_q == TO_LAST) && !rib_rvalid_i;
            end
            default: cnt_d = 8'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT_CYCLES);
    assign timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MBC_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MBC_IDLE: begin
                if (req_ok) begin
                    state_d = (size_i == MEM_SIZE_X) ? MBC_DONE : MBC_REQ;
                end
            end
            MBC_REQ: begin
                if (rib_gnt_i) begin
                    state_d = MBC_RESP;
                end else if (int_assert_i) begin
                    state_d = MBC_IDLE;
                end else if (timeout_hit) begin
                    state_d = MBC_DONE;
                end
            end
            MBC_RESP: begin
                if (rib_rvalid_i) begin
                    state_d = resp_drop ? MBC_IDLE : MBC_DONE;
                end else if (timeout_hit) begin
                    state_d = MBC_DONE;
                end
            end
            default: state_d = MBC_IDLE;
        endcase
    end

    always_comb begin
        req_d      = req_q;
        int_seen_d = int_seen_q;
        rdata_d    = rdata_q;
        err_d      = 1'b0;
        case (state_q)
            MBC_IDLE: begin
                int_seen_d = 1'b0;
                if (req_ok) begin
                    req_d.we    = we_i;
                    req_d.addr  = {in_addr[31:2], 2'b00};
                    req_d.wdata = wdata_i;
                    req_d.sel   = in_sel;
                end
            end
            MBC_REQ: begin
                // A grant coinciding with an interrupt is still a committed transfer.
                int_seen_d = rib_gnt_i & int_assert_i;
            end
            MBC_RESP: begin
                int_seen_d = resp_drop;
                if (rib_rvalid_i && !resp_drop && !req_q.we) begin
                    rdata_d = rib_rdata_i;
                end
            end
            default: int_seen_d = 1'b0;
        endcase
        if (timeout_hit) begin
            rdata_d = ZeroWord;
            err_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q      <= '0;
            int_seen_q <= 1'b0;
            rdata_q    <= ZeroWord;
            err_q      <= 1'b0;
        end else begin
            req_q      <= req_d;
            int_seen_q <= int_seen_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        hold_o      = HoldDisable;
        rib_req_o   = RIB_NREQ;
        rib_we_o    = 1'b0;
        rib_addr_o  = ZeroWord;
        rib_wdata_o = ZeroWord;
        rib_sel_o   = 4'b0000;
        case (state_q)
            MBC_IDLE: begin
                if (req_ok) begin
                    hold_o = HoldEnable;
                end
            end
            MBC_REQ: begin
                hold_o      = HoldEnable;
                rib_req_o   = RIB_REQ;
                rib_we_o    = req_q.we;
                rib_addr_o  = req_q.addr;
                rib_wdata_o = req_q.wdata;
                rib_sel_o   = req_q.sel;
            end
            MBC_RESP: hold_o = HoldEnable;
            default:  hold_o = HoldDisable;
        endcase
    end

    assign rdata_o = rdata_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: transaction-level expectations checked every cycle,
// plus literal checks of addresses, strobes and returned data.
module tb_mem_bus_ctrl;

    logic        clk, rst;
    logic        req_i, we_i, int_assert_i, rib_gnt_i, rib_rvalid_i;
    logic [31:0] raddr_i, waddr_i, wdata_i, rib_rdata_i;
    logic [1:0]  size_i;
    logic        rib_req_o, rib_we_o, hold_o, err_o;
    logic [31:0] rib_addr_o, rib_wdata_o, rdata_o;
    logic [3:0]  rib_sel_o;

    mem_bus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req_i),
        .we_i         (we_i),
        .raddr_i      (raddr_i),
        .waddr_i      (waddr_i),
        .wdata_i      (wdata_i),
        .size_i       (size_i),
        .int_assert_i (int_assert_i),
        .rib_req_o    (rib_req_o),
        .rib_we_o     (rib_we_o),
        .rib_addr_o   (rib_addr_o),
        .rib_wdata_o  (rib_wdata_o),
        .rib_sel_o    (rib_sel_o),
        .rib_gnt_i    (rib_gnt_i),
        .rib_rvalid_i (rib_rvalid_i),
        .rib_rdata_i  (rib_rdata_i),
        .rdata_o      (rdata_o),
        .hold_o       (hold_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    logic        chk_en, mark_done;
    logic        exp_hold, exp_req, exp_we, exp_err;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_sel;
    logic [31:0] model_rdata;

    logic [31:0] lat_addr, lat_rdata;
    logic [3:0]  lat_sel;
    logic        lat_we;
    int          hold_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [3:0] model_sel(input logic [1:0] sz, input logic [1:0] lo);
        logic [3:0] s;
        s = 4'b0000;
        if (sz == 2'b00) s[lo] = 1'b1;
        else if (sz == 2'b01) s = lo[1] ? 4'b1100 : 4'b0011;
        else if (sz == 2'b10) s = 4'b1111;
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle_exp();
        exp_hold  = 1'b0;
        exp_req   = 1'b0;
        exp_we    = 1'b0;
        exp_addr  = 32'h0;
        exp_wdata = 32'h0;
        exp_sel   = 4'h0;
        exp_err   = 1'b0;
        exp_rdata = model_rdata;
    endtask

    task automatic quiet();
        req_i = 1'b0; we_i = 1'b0; int_assert_i = 1'b0;
        rib_gnt_i = 1'b0; rib_rvalid_i = 1'b0; rib_rdata_i = 32'h0;
        raddr_i = 32'h0; waddr_i = 32'h0; wdata_i = 32'h0; size_i = 2'b00;
    endtask

    // Every cycle the expectations describe what the outputs must be right now.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hold",      32'(hold_o),    32'(exp_hold));
            chk("rib_req",   32'(rib_req_o), 32'(exp_req));
            chk("rib_we",    32'(rib_we_o),  32'(exp_we));
            chk("rib_addr",  rib_addr_o,     exp_addr);
            chk("rib_wdata", rib_wdata_o,    exp_wdata);
            chk("rib_sel",   32'(rib_sel_o), 32'(exp_sel));
            chk("rdata",     rdata_o,        exp_rdata);
            chk("err",       32'(err_o),     32'(exp_err));
            if (hold_o === 1'b1) hold_cnt++;
            if (exp_req) begin
                lat_addr = rib_addr_o;
                lat_sel  = rib_sel_o;
                lat_we   = rib_we_o;
            end
            if (mark_done) lat_rdata = rdata_o;
        end
    end

    // One full transaction as the mem stage and bus would present it.
    task automatic do_txn(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input int gnt_wait, input int rv_wait,
                          input int int_req_at, input bit int_resp, input bit gnt_rv,
                          input logic [31:0] rd);
        logic [31:0] a_al;
        logic [3:0]  s;
        bit          aborted;
        a_al    = {addr[31:2], 2'b00};
        s       = model_sel(sz, addr[1:0]);
        aborted = 1'b0;
        quiet();
        req_i = 1'b1; we_i = we; size_i = sz; wdata_i = wd;
        raddr_i = we ? 32'hBAD0_0000 : addr;
        waddr_i = we ? addr : 32'hBAD0_0000;
        set_idle_exp();
        exp_hold = 1'b1;
        step();
        if (sz == 2'b11) begin
            set_idle_exp();
            mark_done = 1'b1;
            step();
            mark_done = 1'b0;
        end else begin
            raddr_i = ~addr; waddr_i = ~addr; wdata_i = ~wd; we_i = ~we; size_i = ~sz;
            for (int i = 0; i <= gnt_wait && !aborted; i++) begin
                set_idle_exp();
                exp_hold = 1'b1; exp_req = 1'b1; exp_we = we;
                exp_addr = a_al; exp_wdata = wd; exp_sel = s;
                rib_gnt_i    = (i == gnt_wait);
                int_assert_i = (i == int_req_at);
                rib_rvalid_i = gnt_rv && (i == gnt_wait);
                rib_rdata_i  = 32'h5A5A_5A5A;
                step();
                if (i == int_req_at && i < gnt_wait) aborted = 1'b1;
            end
            rib_gnt_i = 1'b0; rib_rvalid_i = 1'b0; int_assert_i = 1'b0;
            if (!aborted) begin
                for (int j = 0; j <= rv_wait; j++) begin
                    set_idle_exp();
                    exp_hold     = 1'b1;
                    int_assert_i = int_resp && (j == 0);
                    rib_rvalid_i = (j == rv_wait);
                    rib_rdata_i  = (j == rv_wait) ? rd : 32'h1234_5678;
                    step();
                end
                rib_rvalid_i = 1'b0; int_assert_i = 1'b0;
                if (!int_resp) begin
                    if (!we) model_rdata = rd;
                    set_idle_exp();
                    mark_done = 1'b1;
                    step();
                    mark_done = 1'b0;
                end
            end
        end
        quiet();
        set_idle_exp();
        step();
    endtask

    initial begin
        chk_en = 1'b0; mark_done = 1'b0; hold_cnt = 0;
        lat_addr = 32'h0; lat_rdata = 32'h0; lat_sel = 4'h0; lat_we = 1'b0;
        rst = 1'b0;
        quiet();
        model_rdata = 32'h0;
        set_idle_exp();
        #2 chk_en = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();

        // LW 0x104, best case
        hold_cnt = 0;
        do_txn(1'b0, 32'h0000_0104, 32'h0, 2'b10, 0, 0, -1, 1'b0, 1'b0, 32'hDEAD_BEEF);
        chk("lw_addr", lat_addr, 32'h0000_0104);
        chk("lw_sel", 32'(lat_sel), 32'h0000_000F);
        chk("lw_rdata", lat_rdata, 32'hDEAD_BEEF);
        chk("lw_hold_cycles", 32'(hold_cnt), 32'd3);

        // SB to 0x203
        do_txn(1'b1, 32'h0000_0203, 32'hAB00_0000, 2'b00, 0, 0, -1, 1'b0, 1'b0, 32'h0);
        chk("sb_addr", lat_addr, 32'h0000_0200);
        chk("sb_sel", 32'(lat_sel), 32'h0000_0008);
        chk("sb_we", 32'(lat_we), 32'd1);
        chk("sb_rdata_kept", rdata_o, 32'hDEAD_BEEF);

        // LH 0x102, grant withheld 5 cycles, rvalid alongside grant ignored
        do_txn(1'b0, 32'h0000_0102, 32'h0, 2'b01, 5, 2, -1, 1'b0, 1'b1, 32'hCAFE_F00D);
        chk("lh_sel", 32'(lat_sel), 32'h0000_000C);
        chk("lh_rdata", lat_rdata, 32'hCAFE_F00D);

        // SH 0x0
        do_txn(1'b1, 32'h0000_0000, 32'h0000_BEEF, 2'b01, 1, 1, -1, 1'b0, 1'b0, 32'h0);
        chk("sh_sel", 32'(lat_sel), 32'h0000_0003);

        // interrupt in REQ before grant: abort, no transfer
        do_txn(1'b0, 32'h0000_0500, 32'h0, 2'b10, 3, 0, 1, 1'b0, 1'b0, 32'h7777_7777);
        chk("abort_rdata_kept", rdata_o, 32'hCAFE_F00D);

        // interrupt in RESP: wait for rvalid, discard data
        do_txn(1'b0, 32'h0000_0600, 32'h0, 2'b10, 0, 2, -1, 1'b1, 1'b0, 32'h1111_2222);
        chk("int_resp_rdata", rdata_o, 32'hCAFE_F00D);

        // reserved size: no-op, straight to DONE
        do_txn(1'b0, 32'h0000_0700, 32'h0, 2'b11, 0, 0, -1, 1'b0, 1'b0, 32'h0);

        // request with interrupt in IDLE is not taken
        quiet();
        req_i = 1'b1; raddr_i = 32'h40; size_i = 2'b10; int_assert_i = 1'b1;
        set_idle_exp();
        step();
        quiet();
        set_idle_exp();
        step();

        // LB 0x3F1
        do_txn(1'b0, 32'h0000_03F1, 32'h0, 2'b00, 2, 1, -1, 1'b0, 1'b0, 32'h0000_00EE);
        chk("lb_addr", lat_addr, 32'h0000_03F0);
        chk("lb_sel", 32'(lat_sel), 32'h0000_0002);

`ifdef MEM_BUS_TIMEOUT_EN
        // no grant: timeout after 4 REQ cycles
        quiet();
        req_i = 1'b1; raddr_i = 32'h0000_0400; size_i = 2'b10;
        set_idle_exp();
        exp_hold = 1'b1;
        step();
        for (int i = 0; i < 4; i++) begin
            set_idle_exp();
            exp_hold = 1'b1; exp_req = 1'b1; exp_addr = 32'h0000_0400; exp_sel = 4'hF;
            step();
        end
        model_rdata = 32'h0;
        set_idle_exp();
        exp_err = 1'b1;
        step();
        chk("to_rdata", rdata_o, 32'h0);
        quiet();
        set_idle_exp();
        step();
`endif

        // reset pulled while in RESP
        quiet();
        req_i = 1'b1; raddr_i = 32'h0000_0300; size_i = 2'b10;
        set_idle_exp();
        exp_hold = 1'b1;
        step();
        set_idle_exp();
        exp_hold = 1'b1; exp_req = 1'b1; exp_addr = 32'h0000_0300; exp_sel = 4'hF;
        rib_gnt_i = 1'b1;
        step();
        quiet();
        rst = 1'b0;
        model_rdata = 32'h0;
        set_idle_exp();
        #1;
        chk("rst_hold_async", 32'(hold_o), 32'd0);
        chk("rst_rdata_async", rdata_o, 32'h0);
        step();
        rst = 1'b1;
        step();
        do_txn(1'b0, 32'h0000_0008, 32'h0, 2'b10, 0, 0, -1, 1'b0, 1'b0, 32'h0BAD_F00D);
        chk("post_rst_rdata", lat_rdata, 32'h0BAD_F00D);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
